// File: rtl/uart_receiver_if.sv
// rtl/uart_receiver_if.sv - receive-side result bundle from the UART receiver to system logic
interface uart_receiver_if #(
    parameter int DATA_WIDTH = 8
);
    logic [DATA_WIDTH-1:0] parallel_data;
    logic                  data_valid;
    logic                  parity_error;
    logic                  framing_error;
    logic                  rx_busy;

    modport master (
        output parallel_data,
        output data_valid,
        output parity_error,
        output framing_error,
        output rx_busy
    );

    modport slave (
        input parallel_data,
        input data_valid,
        input parity_error,
        input framing_error,
        input rx_busy
    );
endinterface

// File: rtl/uart_receiver.sv
// rtl/uart_receiver.sv - oversampled UART frame receiver with majority vote, parity and stop checks
module uart_receiver #(
    parameter int DATA_WIDTH = 8
) (
    input  logic             clk,
    input  logic             reset,
    input  logic             serial_data_in,
    input  logic             parity_enable,
    input  logic             parity_type,
    input  logic [5:0]       prescale,
    uart_receiver_if.master  rx
);
    localparam int BW = $clog2(DATA_WIDTH + 3);

    typedef enum logic [2:0] {IDLE, START, DATA, PARITY, STOP} state_t;

    state_t                state, state_next;
    logic [5:0]            p_lat;
    logic                  par_en_lat;
    logic                  par_type_lat;
    logic [5:0]            edge_cnt;
    logic [BW-1:0]         bit_cnt;
    logic                  s0, s1;
    logic [DATA_WIDTH-1:0] shreg;
    logic                  par_bad;
    logic [DATA_WIDTH-1:0] data_q;
    logic                  valid_q, perr_q, ferr_q;

    logic [5:0] half;
    logic       at_s0, at_s1, at_s2;
    logic       maj;
    logic       shift_en, par_check, frame_end;

    // Edge index within the bit selects the three samples around the bit centre
    assign half  = {1'b0, p_lat[5:1]};
    assign at_s0 = (state != IDLE) && (edge_cnt == half - 6'd1);
    assign at_s1 = (state != IDLE) && (edge_cnt == half);
    assign at_s2 = (state != IDLE) && (edge_cnt == half + 6'd1);
    // The third sample is taken live so the decision lands on the same edge
    assign maj   = (s0 & s1) | (s0 & serial_data_in) | (s1 & serial_data_in);

    // Frame state register
    always_ff @(posedge clk) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_next;
        end
    end

    // Next-state and per-edge action decode; state only moves on the third sample
    always_comb begin
        state_next = state;
        shift_en   = 1'b0;
        par_check  = 1'b0;
        frame_end  = 1'b0;
        case (state)
            IDLE: begin
                if (!serial_data_in) state_next = START;
            end
            START: begin
                if (at_s2) state_next = maj ? IDLE : DATA;
            end
            DATA: begin
                if (at_s2) begin
                    shift_en = 1'b1;
                    if (bit_cnt == BW'(DATA_WIDTH))
                        state_next = par_en_lat ? PARITY : STOP;
                end
            end
            PARITY: begin
                if (at_s2) begin
                    par_check  = 1'b1;
                    state_next = STOP;
                end
            end
            STOP: begin
                if (at_s2) begin
                    frame_end  = 1'b1;
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase
    end

    // Counters, sample capture, shift register and registered result pulses
    always_ff @(posedge clk) begin
        if (reset) begin
            p_lat        <= 6'd0;
            par_en_lat   <= 1'b0;
            par_type_lat <= 1'b0;
            edge_cnt     <= 6'd0;
            bit_cnt      <= '0;
            s0           <= 1'b0;
            s1           <= 1'b0;
            shreg        <= '0;
            par_bad      <= 1'b0;
            data_q       <= '0;
            valid_q      <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
        end else begin
            valid_q <= 1'b0;
            perr_q  <= 1'b0;
            ferr_q  <= 1'b0;
            if (state == IDLE) begin
                if (!serial_data_in) begin
                    // This edge is edge 0 of the start bit
                    p_lat        <= prescale;
                    par_en_lat   <= parity_enable;
                    par_type_lat <= parity_type;
                    edge_cnt     <= 6'd1;
                    bit_cnt      <= '0;
                    par_bad      <= 1'b0;
                end
            end else begin
                if (edge_cnt == p_lat - 6'd1) begin
                    edge_cnt <= 6'd0;
                    bit_cnt  <= bit_cnt + BW'(1);
                end else begin
                    edge_cnt <= edge_cnt + 6'd1;
                end
                if (at_s0) s0 <= serial_data_in;
                if (at_s1) s1 <= serial_data_in;
                if (shift_en) shreg <= {maj, shreg[DATA_WIDTH-1:1]};
                if (par_check) par_bad <= (maj != (^shreg ^ par_type_lat));
                if (frame_end) begin
                    perr_q <= par_bad;
                    ferr_q <= ~maj;
                    if (!par_bad && maj) begin
                        data_q  <= shreg;
                        valid_q <= 1'b1;
                    end
                end
            end
        end
    end

    assign rx.parallel_data = data_q;
    assign rx.data_valid    = valid_q;
    assign rx.parity_error  = perr_q;
    assign rx.framing_error = ferr_q;
    assign rx.rx_busy       = (state != IDLE);
endmodule

// File: tb/tb_uart_receiver.sv
// tb/tb_uart_receiver.sv - directed self-checking bench for uart_receiver
module tb_uart_receiver;
    logic       clk = 1'b0;
    logic       reset;
    logic       serial_data_in;
    logic       parity_enable;
    logic       parity_type;
    logic [5:0] prescale;

    uart_receiver_if #(.DATA_WIDTH(8)) rx_if ();

    uart_receiver #(.DATA_WIDTH(8)) dut (
        .clk            (clk),
        .reset          (reset),
        .serial_data_in (serial_data_in),
        .parity_enable  (parity_enable),
        .parity_type    (parity_type),
        .prescale       (prescale),
        .rx             (rx_if)
    );

    always #5 clk = ~clk;

    int errors = 0;
    int checks = 0;

    logic line_q[$];
    logic busy_a [0:511];
    int   dv_cnt, dv_first_at, dv_last_at;
    logic [7:0] dv_first_pd, dv_last_pd;
    int   pe_cnt, pe_at, fe_cnt, fe_at;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic add_bits(input logic b, input int n);
        for (int i = 0; i < n; i++) line_q.push_back(b);
    endtask

    task automatic add_frame(input logic [7:0] d, input int p, input bit has_par,
                             input logic par_bit, input logic stop_bit);
        add_bits(1'b0, p);
        for (int i = 0; i < 8; i++) add_bits(d[i], p);
        if (has_par) add_bits(par_bit, p);
        add_bits(stop_bit, p);
    endtask

    // Edge k of the run is the k-th posedge after the call; k=0 is E0 when the queue starts with a frame
    task automatic run(input int rst_edge, input logic [5:0] mid_p);
        int n;
        n = line_q.size();
        dv_cnt = 0; dv_first_at = -1; dv_last_at = -1;
        dv_first_pd = 8'h00; dv_last_pd = 8'h00;
        pe_cnt = 0; pe_at = -1; fe_cnt = 0; fe_at = -1;
        for (int k = 0; k < n; k++) begin
            serial_data_in = line_q[k];
            reset = (k == rst_edge);
            if (k == 10 && mid_p != 6'd0) prescale = mid_p;
            @(posedge clk);
            #1;
            busy_a[k] = rx_if.rx_busy;
            if (rx_if.data_valid) begin
                dv_cnt++;
                if (dv_cnt == 1) begin
                    dv_first_at = k;
                    dv_first_pd = rx_if.parallel_data;
                end
                dv_last_at = k;
                dv_last_pd = rx_if.parallel_data;
            end
            if (rx_if.parity_error) begin
                pe_cnt++;
                if (pe_cnt == 1) pe_at = k;
            end
            if (rx_if.framing_error) begin
                fe_cnt++;
                if (fe_cnt == 1) fe_at = k;
            end
        end
        reset = 1'b0;
        serial_data_in = 1'b1;
        line_q.delete();
    endtask

    initial begin
        reset = 1'b1;
        serial_data_in = 1'b1;
        parity_enable = 1'b0;
        parity_type = 1'b0;
        prescale = 6'd8;
        repeat (3) @(posedge clk);
        #1;
        reset = 1'b0;
        check("reset_data", rx_if.parallel_data, 8'h00);
        check("reset_valid", rx_if.data_valid, 1'b0);
        check("reset_perr", rx_if.parity_error, 1'b0);
        check("reset_ferr", rx_if.framing_error, 1'b0);
        check("reset_busy", rx_if.rx_busy, 1'b0);
        @(posedge clk);
        #1;

        // P=8, no parity, 0xA5
        prescale = 6'd8; parity_enable = 1'b0;
        add_frame(8'hA5, 8, 0, 1'b0, 1'b1); add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("a5_dv_cnt", dv_cnt, 1);
        check("a5_dv_at", dv_first_at, 77);
        check("a5_data", dv_first_pd, 8'hA5);
        check("a5_perr", pe_cnt, 0);
        check("a5_ferr", fe_cnt, 0);
        check("a5_busy_e0", busy_a[0], 1'b1);
        check("a5_busy_e76", busy_a[76], 1'b1);
        check("a5_busy_e77", busy_a[77], 1'b0);

        // P=16, even parity, 0x3C with correct parity 0
        prescale = 6'd16; parity_enable = 1'b1; parity_type = 1'b0;
        add_frame(8'h3C, 16, 1, 1'b0, 1'b1); add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("3c_dv_cnt", dv_cnt, 1);
        check("3c_dv_at", dv_first_at, 169);
        check("3c_data", dv_first_pd, 8'h3C);
        check("3c_perr", pe_cnt, 0);

        // Same with wrong parity bit 1
        add_frame(8'h3C, 16, 1, 1'b1, 1'b1); add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("par_perr_cnt", pe_cnt, 1);
        check("par_perr_at", pe_at, 169);
        check("par_dv_cnt", dv_cnt, 0);
        check("par_ferr", fe_cnt, 0);
        check("par_data_hold", rx_if.parallel_data, 8'h3C);

        // P=8, 0x5A with stop bit 0
        prescale = 6'd8; parity_enable = 1'b0;
        add_frame(8'h5A, 8, 0, 1'b0, 1'b0); add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("ferr_cnt", fe_cnt, 1);
        check("ferr_at", fe_at, 77);
        check("ferr_dv_cnt", dv_cnt, 0);
        check("ferr_perr", pe_cnt, 0);
        check("ferr_data_hold", rx_if.parallel_data, 8'h3C);

        // P=8, odd parity, 0x01 with parity 0; prescale changed mid-frame must be ignored
        prescale = 6'd8; parity_enable = 1'b1; parity_type = 1'b1;
        add_frame(8'h01, 8, 1, 1'b0, 1'b1); add_bits(1'b1, 20);
        run(-1, 6'd20);
        check("odd_dv_cnt", dv_cnt, 1);
        check("odd_dv_at", dv_first_at, 85);
        check("odd_data", dv_first_pd, 8'h01);
        check("odd_perr", pe_cnt, 0);

        // Start glitch: low for E0-E1 only
        prescale = 6'd8; parity_enable = 1'b0; parity_type = 1'b0;
        add_bits(1'b0, 2); add_bits(1'b1, 30);
        run(-1, 6'd0);
        check("glitch_busy_e4", busy_a[4], 1'b1);
        check("glitch_busy_e5", busy_a[5], 1'b0);
        check("glitch_pulses", dv_cnt + pe_cnt + fe_cnt, 0);

        // One-cycle low at centre sample of data bit 3 (frame bit 4, edge 36) of 0xFF
        add_frame(8'hFF, 8, 0, 1'b0, 1'b1); add_bits(1'b1, 20);
        line_q[36] = 1'b0;
        run(-1, 6'd0);
        check("vote_dv_at", dv_first_at, 77);
        check("vote_data", dv_first_pd, 8'hFF);

        // Back-to-back 0x01 then 0x80
        add_frame(8'h01, 8, 0, 1'b0, 1'b1);
        add_frame(8'h80, 8, 0, 1'b0, 1'b1);
        add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("b2b_dv_cnt", dv_cnt, 2);
        check("b2b_first_at", dv_first_at, 77);
        check("b2b_first_data", dv_first_pd, 8'h01);
        check("b2b_last_at", dv_last_at, 157);
        check("b2b_last_data", dv_last_pd, 8'h80);

        // Third frame 0xF0 with reset at E40; line stays high after E40
        add_frame(8'hF0, 8, 0, 1'b0, 1'b1); add_bits(1'b1, 20);
        run(40, 6'd0);
        check("rst_pulses", dv_cnt + pe_cnt + fe_cnt, 0);
        check("rst_busy_e39", busy_a[39], 1'b1);
        check("rst_busy_e40", busy_a[40], 1'b0);
        check("rst_data_clr", rx_if.parallel_data, 8'h00);

        // Fresh frame after reset
        add_frame(8'h6B, 8, 0, 1'b0, 1'b1); add_bits(1'b1, 20);
        run(-1, 6'd0);
        check("post_rst_dv_at", dv_first_at, 77);
        check("post_rst_data", dv_first_pd, 8'h6B);

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule

// File: doc/uart_receiver.md
# uart_receiver

Receive half of the UART: recovers `DATA_WIDTH`-bit frames from the serial line using `prescale`-times oversampling and a 3-sample majority vote per bit. It checks the optional parity bit and the stop bit, and presents each good byte as a one-cycle `data_valid` pulse. It runs on the UART oversampling clock and sits between the line synchronizer and the system-side receive logic. It is the counterpart to the transmit-side serializer.

## Interface
- `DATA_WIDTH`, default 8: payload bits per frame.
- `clk`  input  1: UART oversampling clock, `prescale` cycles per bit.
- `reset`  input  1: synchronous, active-high reset.
- `serial_data_in`  input  1: RX line, already synchronized to `clk`. Idles high.
- `parity_enable`  input  1: 1 means a parity bit follows the data.
- `parity_type`  input  1: 0 = even, 1 = odd.
- `prescale`  input  6: oversampling ratio. Legal values are even numbers from 8 to 62; any other value gives undefined behaviour.
- `parallel_data`  output  `DATA_WIDTH`: last good payload, LSB received first.
- `data_valid`  output  1: one-cycle pulse when `parallel_data` updates.
- `parity_error`  output  1: one-cycle pulse at end of a frame with bad parity.
- `framing_error`  output  1: one-cycle pulse at end of a frame whose stop bit samples 0.
- `rx_busy`  output  1: high while a frame is in progress.

## Operation
- Reset behaviour: every output is 0, `parallel_data` is 0, and the FSM is in IDLE.
- FSM states: IDLE → START → DATA → PARITY (only if enabled) → STOP → IDLE.
- IDLE: a clock edge E0 that samples `serial_data_in`=0 starts a frame.
  - The same edge latches `prescale`, `parity_enable` and `parity_type` for the whole frame.
  - Mid-frame changes to those inputs are ignored.
- Bit numbering: frame bit n is n=0 for start, 1..`DATA_WIDTH` for data, then parity, then stop.
  - N denotes the stop bit's index: `DATA_WIDTH`+1 without parity, `DATA_WIDTH`+2 with parity.
- Sampling: with P = latched prescale, bit n is sampled at edges E(nP + P/2 − 1), E(nP + P/2) and E(nP + P/2 + 1). The bit value is the majority of those 3 samples.
- Counters:
  - The edge counter runs 0..P−1 and wraps to 0 at each bit boundary.
  - The bit counter increments on each wrap.
  - Edge E0 counts as edge 0 of bit 0.
- START: if the majority is 1 (glitch), return to IDLE at edge E(P/2 + 1) with no outputs.
- DATA: bits are shifted in LSB first.
- PARITY: expected parity is the XOR of the data bits, inverted when `parity_type`=1. A mismatch sets `parity_error`.
- STOP: a majority of 0 sets `framing_error`.
  - If neither error is set, load `parallel_data` and pulse `data_valid`.
  - `parity_error` and `framing_error` may pulse together.
  - On any error, `parallel_data` holds its previous value.
- Return to IDLE at the third stop sample. Remaining stop-bit time is spent in IDLE, so a new start can be detected on the very next edge.

## Timing
- End of frame: all outputs update at edge E(NP + P/2 + 1).
  - They are registered, using the current sample inside the majority vote.
  - Pulses last exactly one cycle.
- Latency examples:
  - P=8, 8 data bits, no parity: end of frame at E77.
  - Same, with parity: end of frame at E85.
- `rx_busy`: rises at E0 and falls at the end-of-frame edge, or at the glitch-abort edge.
- Reset mid-frame: `reset` high at any edge forces IDLE and clears all outputs at that edge. After release, the receiver waits for a fresh 0 in IDLE.
- A 0 seen in IDLE while the line is stuck low starts a new frame on every detection. A continuously low line therefore produces repeated framing errors, not a hang.

## Test plan
- P=8, no parity, send 0xA5 (bits 1,0,1,0,0,1,0,1 LSB first), stop=1:
  - `data_valid` pulses at E77 with `parallel_data`=0xA5.
  - `rx_busy` is high from E0 to E77.
- P=16, even parity, send 0x3C with parity bit 0:
  - Valid at E(10·16+9)=E169 with data 0x3C.
  - Repeat with parity bit 1: `parity_error` pulses at E169, no `data_valid`, data unchanged.
- P=8, send 0x5A with stop bit 0: `framing_error` pulses at E77, no `data_valid`, `parallel_data` keeps the prior value.
- P=8, line low only for edges E0–E1, then high: abort at E5, no pulses, `rx_busy` low after E5.
- P=8, a one-cycle low glitch at the centre sample of data bit 3 of 0xFF: majority recovers the bit and 0xFF is delivered.
- Two back-to-back frames 0x01 and 0x80 with one stop bit each, plus `reset` asserted at E40 of a third frame:
  - Both frames are valid.
  - The third frame produces no pulses.
  - The receiver accepts a new frame after reset.
